mdu_multicycle: RTL and testbench

//   E-stage multiply/divide unit. Consumes MDUType from the E-stage control decode plus the

---
 rtl/mdu_multicycle.sv | 168 ++++++++++++++++
 tb/tb_mdu_multicycle.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_multicycle.sv
// E-stage multiply/divide unit with architectural HI/LO registers.
// The result is computed when the operation is accepted, then held back for a
// fixed number of cycles (busy) to model the latency of a real multi-cycle unit.
module mdu_multicycle #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  MDUType,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDUO,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic        r_res_wr;

    // mult/multu/div/divu all share the encoding 5'b001xx
    logic        w_is_md;
    logic        w_signed_div;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_num;
    logic [31:0] w_den;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_wr;
    logic [CW-1:0] w_cnt_load;

    assign w_is_md      = (MDUType[4:2] == 3'b001);
    assign w_signed_div = (MDUType[1:0] == 2'd2);

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed division goes through magnitudes so 0x80000000 / -1 wraps cleanly
    // to 0x80000000 instead of relying on tool overflow behaviour.
    assign w_a_mag = A[31] ? (32'd0 - A) : A;
    assign w_b_mag = B[31] ? (32'd0 - B) : B;
    assign w_num   = w_signed_div ? w_a_mag : A;
    // A zero divisor never commits; substitute 1 to keep the divider defined.
    assign w_den   = (B == 32'd0) ? 32'd1 : (w_signed_div ? w_b_mag : B);
    assign w_uq    = w_num / w_den;
    assign w_ur    = w_num % w_den;

    assign w_cnt_load = MDUType[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    // Select the pending result for the operation being accepted
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_wr = 1'b1;
        case (MDUType[1:0])
            2'd0: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            2'd1: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            2'd2: begin
                w_res_lo = (A[31] ^ B[31]) ? (32'd0 - w_uq) : w_uq;
                w_res_hi = A[31] ? (32'd0 - w_ur) : w_ur;
                w_res_wr = (B != 32'd0);
            end
            default: begin
                w_res_lo = w_uq;
                w_res_hi = w_ur;
                w_res_wr = (B != 32'd0);
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the start strobe to hazard logic
    always_comb begin
        w_state_next = r_state;
        start        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && w_is_md) begin
                    start        = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            default: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    // Counter, pending result and HI/LO updates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_wr <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_res_hi <= w_res_hi;
                r_res_lo <= w_res_lo;
                r_res_wr <= w_res_wr;
                r_cnt    <= w_cnt_load;
            end else if (en && MDUType == 5'd2) begin
                r_hi <= A;
            end else if (en && MDUType == 5'd3) begin
                r_lo <= A;
            end
        end else begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1) && r_res_wr) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
        end
    end

    // Read-out paths: busy from state, MDUO straight from HI/LO
    always_comb begin
        busy = (r_state == S_BUSY);
        HI   = r_hi;
        LO   = r_lo;
        MDUO = 32'd0;
        if (MDUType == 5'd0) begin
            MDUO = r_hi;
        end else if (MDUType == 5'd1) begin
            MDUO = r_lo;
        end
    end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_mdu_multicycle;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [4:0]  MDUType = 5'd31;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        start;
    logic        busy;
    logic [31:0] MDUO;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model: architectural HI/LO plus "cycles left" of the pending op
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_phi = 32'd0;
    logic [31:0] m_plo = 32'd0;
    logic        m_wr = 1'b0;
    int          m_left = 0;

    mdu_multicycle #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .MDUType (MDUType),
        .A       (A),
        .B       (B),
        .start   (start),
        .busy    (busy),
        .MDUO    (MDUO),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic done in 64-bit integers
    task automatic model_compute(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        m_wr = 1'b1;
        case (t)
            5'd4: begin
                p = sa * sb;
                m_phi = p[63:32];
                m_plo = p[31:0];
            end
            5'd5: begin
                pu = ua * ub;
                m_phi = pu[63:32];
                m_plo = pu[31:0];
            end
            5'd6: begin
                if (b == 32'd0) m_wr = 1'b0;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_plo = q[31:0];
                    m_phi = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) m_wr = 1'b0;
                else begin
                    m_plo = a / b;
                    m_phi = a % b;
                end
            end
        endcase
        m_left = (t >= 5'd6) ? DIV_N : MULT_N;
    endtask

    // One clock cycle: drive, check combinational/registered outputs, advance model
    task automatic cycle(input logic e, input logic [4:0] t, input logic [31:0] a, input logic [31:0] b);
        logic exp_start;
        logic [31:0] exp_mduo;
        @(negedge clk);
        en = e; MDUType = t; A = a; B = b;
        #1;
        exp_start = e && (m_left == 0) && (t >= 5'd4) && (t <= 5'd7);
        exp_mduo  = (t == 5'd0) ? m_hi : ((t == 5'd1) ? m_lo : 32'd0);
        check_val("start", {31'd0, start}, {31'd0, exp_start});
        check_val("busy", {31'd0, busy}, {31'd0, m_left > 0});
        check_val("mduo", MDUO, exp_mduo);
        check_val("hi", HI, m_hi);
        check_val("lo", LO, m_lo);
        $display("[TB] en=%0b type=%0d A=%08h B=%08h start=%0b busy=%0b MDUO=%08h HI=%08h LO=%08h",
                 e, t, a, b, start, busy, MDUO, HI, LO);
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (e) begin
            if (t >= 5'd4 && t <= 5'd7) model_compute(t, a, b);
            else if (t == 5'd2) m_hi = a;
            else if (t == 5'd3) m_lo = a;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd31, $urandom, $urandom);
    endtask

    initial begin
        logic [4:0] types [9];
        logic [4:0] t;
        logic [31:0] a, b;
        int sel;
        types = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd31};

        // Reset state
        #2;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_hi", HI, 32'd0);
        check_val("rst_lo", LO, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // mult -2 * 3
        cycle(1'b1, 5'd4, 32'hFFFFFFFE, 32'd3);
        idle(MULT_N);
        #1;
        check_val("t1_hi", HI, 32'hFFFFFFFF);
        check_val("t1_lo", LO, 32'hFFFFFFFA);
        cycle(1'b1, 5'd0, 32'd0, 32'd0);

        // multu max * max
        cycle(1'b1, 5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF);
        idle(MULT_N);
        #1;
        check_val("t2_hi", HI, 32'hFFFFFFFE);
        check_val("t2_lo", LO, 32'h00000001);

        // div -7 / 2, divu 7 / 2, div overflow case
        cycle(1'b1, 5'd6, 32'hFFFFFFF9, 32'd2);
        idle(DIV_N);
        #1;
        check_val("t3_lo", LO, 32'hFFFFFFFD);
        check_val("t3_hi", HI, 32'hFFFFFFFF);
        cycle(1'b1, 5'd7, 32'd7, 32'd2);
        idle(DIV_N);
        #1;
        check_val("t3u_lo", LO, 32'd3);
        check_val("t3u_hi", HI, 32'd1);
        cycle(1'b1, 5'd6, 32'h80000000, 32'hFFFFFFFF);
        idle(DIV_N);
        #1;
        check_val("t3o_lo", LO, 32'h80000000);
        check_val("t3o_hi", HI, 32'd0);

        // mthi then mflo, then divide by zero
        cycle(1'b1, 5'd2, 32'h12345678, 32'd0);
        cycle(1'b1, 5'd1, 32'd0, 32'd0);
        cycle(1'b1, 5'd7, 32'd55, 32'd0);
        idle(DIV_N);
        #1;
        check_val("t4_hi", HI, 32'h12345678);
        check_val("t4_lo", LO, 32'h80000000);

        // Ops issued while busy are dropped; next mult accepted at t+6
        cycle(1'b1, 5'd4, 32'd100, 32'd7);
        cycle(1'b0, 5'd31, 32'd0, 32'd0);
        cycle(1'b1, 5'd3, 32'hAA, 32'd0);
        cycle(1'b1, 5'd4, 32'd9, 32'd9);
        cycle(1'b0, 5'd31, 32'd0, 32'd0);
        cycle(1'b0, 5'd31, 32'd0, 32'd0);
        #1;
        check_val("t5_lo", LO, 32'd700);
        cycle(1'b1, 5'd4, 32'd3, 32'd4);
        idle(MULT_N);

        // Async reset in the middle of a divide
        cycle(1'b1, 5'd6, 32'd1000, 32'd3);
        idle(3);
        @(negedge clk);
        en = 1'b0; MDUType = 5'd31;
        #2 reset = 1'b0;
        #1;
        check_val("t6_busy", {31'd0, busy}, 32'd0);
        check_val("t6_hi", HI, 32'd0);
        check_val("t6_lo", LO, 32'd0);
        m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        #2 reset = 1'b1;
        idle(DIV_N + 3);

        // Randomized traffic
        for (int n = 0; n < 700; n++) begin
            t = types[$urandom_range(0, 8)];
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel < 5) b = $urandom_range(1, 20);
            cycle(($urandom_range(0, 4) != 0), t, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net against a stuck simulation
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
